// File: rtl/rgb565_binarize_pkg.sv
// Shared constants and types for the RGB565 binarization pipeline:
// luma coefficients, RGB565 field positions and the 5/6-bit to 8-bit expansion.
package rgb565_binarize_pkg;

    localparam int unsigned LUMA_COEF_R = 77;
    localparam int unsigned LUMA_COEF_G = 150;
    localparam int unsigned LUMA_COEF_B = 29;
    localparam int unsigned LUMA_SHIFT  = 8;

    localparam int unsigned R_MSB = 15;
    localparam int unsigned R_LSB = 11;
    localparam int unsigned G_MSB = 10;
    localparam int unsigned G_LSB = 5;
    localparam int unsigned B_MSB = 4;
    localparam int unsigned B_LSB = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef struct packed {
        logic vsync;
        logic href;
        logic clken;
    } sync_t;

    // Replicating the top bits maps full-scale 5/6-bit values onto 255 exactly.
    function automatic rgb888_t expand_rgb565(input logic [15:0] pix);
        rgb888_t c;
        c.r = {pix[R_MSB:R_LSB], pix[R_MSB -: 3]};
        c.g = {pix[G_MSB:G_LSB], pix[G_MSB -: 2]};
        c.b = {pix[B_MSB:B_LSB], pix[B_MSB -: 3]};
        return c;
    endfunction

endpackage

// File: rtl/rgb565_binarize_gray.sv
// Two-stage RGB565 to 8-bit luma datapath: stage 1 registers the weighted
// channel products, stage 2 registers their sum; gray is the sum's upper byte.
module rgb565_to_gray
    import rgb565_binarize_pkg::*;
(
    input  logic        cmos_pclk,
    input  logic        rst_n,
    input  logic [15:0] pix_in,
    output logic [7:0]  gray
);

    rgb888_t     rgb;
    logic [15:0] prod_r_d, prod_r_q;
    logic [15:0] prod_g_d, prod_g_q;
    logic [15:0] prod_b_d, prod_b_q;
    logic [15:0] sum_d, sum_q;

    always_comb begin
        rgb      = expand_rgb565(pix_in);
        prod_r_d = 16'(LUMA_COEF_R) * 16'(rgb.r);
        prod_g_d = 16'(LUMA_COEF_G) * 16'(rgb.g);
        prod_b_d = 16'(LUMA_COEF_B) * 16'(rgb.b);
        // Coefficients sum to 256, so the total tops out at 65280 and fits 16 bits.
        sum_d    = prod_r_q + prod_g_q + prod_b_q;
    end

    always_ff @(posedge cmos_pclk) begin
        if (!rst_n) begin
            prod_r_q <= '0;
            prod_g_q <= '0;
            prod_b_q <= '0;
            sum_q    <= '0;
        end else begin
            prod_r_q <= prod_r_d;
            prod_g_q <= prod_g_d;
            prod_b_q <= prod_b_d;
            sum_q    <= sum_d;
        end
    end

    assign gray = 8'(sum_q >> LUMA_SHIFT);

endmodule

// File: rtl/rgb565_binarize.sv
// RGB565 binarization stage: luma, per-frame threshold, 3-cycle sync re-timing,
// pixel coordinates and a per-frame white-pixel count.
module rgb565_binarize
    import rgb565_binarize_pkg::*;
#(
    parameter int unsigned X_BITS   = 11,
    parameter int unsigned Y_BITS   = 10,
    parameter int unsigned CNT_BITS = 20
) (
    input  logic                cmos_pclk,
    input  logic                rst_n,
    input  logic                in_vsync,
    input  logic                in_href,
    input  logic                in_clken,
    input  logic [15:0]         in_data,
    input  logic [7:0]          threshold,
    output logic                out_vsync,
    output logic                out_href,
    output logic                out_clken,
    output logic [7:0]          out_gray,
    output logic                out_bin,
    output logic [X_BITS-1:0]   out_x,
    output logic [Y_BITS-1:0]   out_y,
    output logic [CNT_BITS-1:0] white_count,
    output logic                white_count_valid
);

    sync_t               sync1_d, sync1_q;
    sync_t               sync2_d, sync2_q;
    sync_t               sync3_d, sync3_q;
    logic [7:0]          gray_s2;
    logic [7:0]          gray_d, gray_q;
    logic                bin_d, bin_q;
    logic [7:0]          thr_d, thr_q;
    logic                armed_d, armed_q;
    logic                vs_in_prev_d, vs_in_prev_q;
    logic                vs_low_seen_d, vs_low_seen_q;
    logic                vs_out_prev_d, vs_out_prev_q;
    logic                hs_out_prev_d, hs_out_prev_q;
    logic [X_BITS-1:0]   x_d, x_q;
    logic [Y_BITS-1:0]   y_d, y_q;
    logic [CNT_BITS-1:0] acc_d, acc_q;
    logic [CNT_BITS-1:0] white_count_d, white_count_q;
    logic                wc_valid_d, wc_valid_q;

    logic frame_start;
    logic frame_end;
    logic vs_out_rise;
    logic line_end;
    logic pix_valid;

    rgb565_to_gray u_gray (
        .cmos_pclk (cmos_pclk),
        .rst_n     (rst_n),
        .pix_in    (in_data),
        .gray      (gray_s2)
    );

    always_comb begin
        sync1_d.vsync = in_vsync;
        sync1_d.href  = in_href;
        sync1_d.clken = in_clken;
        sync2_d       = sync1_q;
        sync3_d       = sync2_q;

        gray_d = sync2_q.clken ? gray_s2 : gray_q;
        bin_d  = sync2_q.clken ? (gray_s2 >= thr_q) : bin_q;

        // A vsync already high out of reset is not a frame start: a low must be seen first.
        frame_start   = in_vsync & ~vs_in_prev_q & vs_low_seen_q;
        thr_d         = frame_start ? threshold : thr_q;
        armed_d       = armed_q | frame_start;
        vs_in_prev_d  = in_vsync;
        vs_low_seen_d = vs_low_seen_q | ~in_vsync;

        vs_out_prev_d = sync3_q.vsync;
        hs_out_prev_d = sync3_q.href;
        frame_end     = vs_out_prev_q & ~sync3_q.vsync;
        vs_out_rise   = sync3_q.vsync & ~vs_out_prev_q;
        line_end      = hs_out_prev_q & ~sync3_q.href;
        pix_valid     = sync3_q.clken & sync3_q.href;

        x_d = x_q;
        if (line_end) begin
            x_d = '0;
        end else if (pix_valid && (x_q != '1)) begin
            x_d = x_q + 1'b1;
        end

        y_d = y_q;
        if (vs_out_rise) begin
            y_d = '0;
        end else if (line_end && (y_q != '1)) begin
            y_d = y_q + 1'b1;
        end

        acc_d         = acc_q;
        white_count_d = white_count_q;
        wc_valid_d    = 1'b0;
        if (frame_end && armed_q) begin
            white_count_d = acc_q;
            wc_valid_d    = 1'b1;
            acc_d         = '0;
        end else if (armed_q && pix_valid && bin_q && (acc_q != '1)) begin
            acc_d = acc_q + 1'b1;
        end
    end

    always_ff @(posedge cmos_pclk) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            sync3_q       <= '0;
            gray_q        <= '0;
            bin_q         <= 1'b0;
            thr_q         <= '0;
            armed_q       <= 1'b0;
            vs_in_prev_q  <= 1'b0;
            vs_low_seen_q <= 1'b0;
            vs_out_prev_q <= 1'b0;
            hs_out_prev_q <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            acc_q         <= '0;
            white_count_q <= '0;
            wc_valid_q    <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            sync3_q       <= sync3_d;
            gray_q        <= gray_d;
            bin_q         <= bin_d;
            thr_q         <= thr_d;
            armed_q       <= armed_d;
            vs_in_prev_q  <= vs_in_prev_d;
            vs_low_seen_q <= vs_low_seen_d;
            vs_out_prev_q <= vs_out_prev_d;
            hs_out_prev_q <= hs_out_prev_d;
            x_q           <= x_d;
            y_q           <= y_d;
            acc_q         <= acc_d;
            white_count_q <= white_count_d;
            wc_valid_q    <= wc_valid_d;
        end
    end

    assign out_vsync         = sync3_q.vsync;
    assign out_href          = sync3_q.href;
    assign out_clken         = sync3_q.clken;
    assign out_gray          = gray_q;
    assign out_bin           = bin_q;
    assign out_x             = x_q;
    assign out_y             = y_q;
    assign white_count       = white_count_q;
    assign white_count_valid = wc_valid_q;

endmodule
